week_stepper: RTL and testbench

Sequential, parametrised weekday projector. Given a start date (day, month, year) and its known weekday, it walks forward month by month and streams the weekday that the same day-of-month falls on in each of the next `steps_in` months. It replaces the fixed two-month combinational projector in the calendar datapath, adding year tracking, a run-time step count, existence flags and output backpressure.

---
 rtl/calendar_pkg.sv | 43 ++++
 rtl/leap_year_check.sv | 22 ++
 rtl/week_stepper.sv | 197 +++++++++++++++++++
 tb/tb_week_stepper.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/calendar_pkg.sv
// Shared calendar types, constants and helpers for the weekday stepper datapath.
package calendar_pkg;

    typedef enum logic [1:0] {StIdle, StCheck, StRun, StErr} state_e;

    localparam logic [2:0] SUN        = 3'd0;
    localparam logic [2:0] MON        = 3'd1;
    localparam logic [2:0] TUE        = 3'd2;
    localparam logic [2:0] WED        = 3'd3;
    localparam logic [2:0] THU        = 3'd4;
    localparam logic [2:0] FRI        = 3'd5;
    localparam logic [2:0] SAT        = 3'd6;
    localparam logic [2:0] WK_INVALID = 3'd7;

    localparam logic [3:0] JAN = 4'd1;
    localparam logic [3:0] FEB = 4'd2;
    localparam logic [3:0] APR = 4'd4;
    localparam logic [3:0] JUN = 4'd6;
    localparam logic [3:0] SEP = 4'd9;
    localparam logic [3:0] NOV = 4'd11;
    localparam logic [3:0] DEC = 4'd12;

    function automatic logic [4:0] days_in_month(input logic [3:0] mon, input logic leap);
        logic [4:0] d;
        case (mon)
            FEB:                d = leap ? 5'd29 : 5'd28;
            APR, JUN, SEP, NOV: d = 5'd30;
            default:            d = 5'd31;
        endcase
        return d;
    endfunction

    // Both operands are 0..6, so a single conditional subtract is enough.
    function automatic logic [2:0] mod7_add(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 4'd7) begin
            s = s - 4'd7;
        end
        return s[2:0];
    endfunction

endpackage

// File: rtl/leap_year_check.sv
// Gregorian leap-year flag for a YEAR_W-bit year; divisors are constants.
module leap_year_check #(
    parameter int unsigned YEAR_W = 12
) (
    input  logic [YEAR_W-1:0] year,
    output logic              leap
);

    logic [31:0] year32;
    logic        div4;
    logic        div100;
    logic        div400;

    always_comb begin
        year32 = 32'(year);
        div4   = (year32[1:0] == 2'b00);
        div100 = ((year32 % 32'd100) == 32'd0);
        div400 = ((year32 % 32'd400) == 32'd0);
        leap   = (div4 && !div100) || div400;
    end

endmodule

// File: rtl/week_stepper.sv
// Streams the weekday of a fixed day-of-month over successive months with backpressure.
// Leap-year handling is enabled by defining WEEK_STEPPER_LEAP_EN.
module week_stepper
    import calendar_pkg::*;
#(
    parameter int unsigned STEPS_W = 4,
    parameter int unsigned YEAR_W  = 12
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         date_in,
    input  logic [3:0]         mon_in,
    input  logic [YEAR_W-1:0]  year_in,
    input  logic [2:0]         week_in,
    input  logic [STEPS_W-1:0] steps_in,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         mon_out,
    output logic [YEAR_W-1:0]  year_out,
    output logic [2:0]         week_out,
    output logic               exists_out,
    output logic               out_last,
    output logic               err,
    output logic               done
);

    state_e             state_q, state_d;
    logic [4:0]         date_q, date_d;
    logic [3:0]         cur_mon_q, cur_mon_d;
    logic [YEAR_W-1:0]  cur_year_q, cur_year_d;
    logic [2:0]         cur_week_q, cur_week_d;
    logic [STEPS_W-1:0] cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               err_q, err_d;
    logic               done_q, done_d;
    logic               exists_q, exists_d;
    logic [3:0]         mon_out_q, mon_out_d;
    logic [YEAR_W-1:0]  year_out_q, year_out_d;
    logic [2:0]         week_out_q, week_out_d;

    logic               leap_cur;
    logic               leap_nxt;
    logic [4:0]         cur_days;
    logic [4:0]         offset5;
    logic [3:0]         nxt_mon;
    logic [YEAR_W-1:0]  nxt_year;
    logic [2:0]         nxt_week;
    logic               nxt_exists;
    logic               in_valid;
    logic [STEPS_W-1:0] rem_cnt;

`ifdef WEEK_STEPPER_LEAP_EN
    leap_year_check #(.YEAR_W(YEAR_W)) u_leap_cur (.year(cur_year_q), .leap(leap_cur));
    leap_year_check #(.YEAR_W(YEAR_W)) u_leap_nxt (.year(nxt_year), .leap(leap_nxt));
`else
    assign leap_cur = 1'b0;
    assign leap_nxt = 1'b0;
`endif

    // The current-month registers double as the captured start date during CHECK.
    always_comb begin
        cur_days   = days_in_month(cur_mon_q, leap_cur);
        offset5    = cur_days - 5'd28;
        nxt_week   = mod7_add(cur_week_q, offset5[2:0]);
        nxt_mon    = (cur_mon_q == DEC) ? JAN : cur_mon_q + 4'd1;
        nxt_year   = (cur_mon_q == DEC) ? cur_year_q + YEAR_W'(1) : cur_year_q;
        nxt_exists = (date_q <= days_in_month(nxt_mon, leap_nxt));
        in_valid   = (cur_mon_q != 4'd0) && (cur_mon_q <= DEC) && (cur_week_q != WK_INVALID) &&
                     (date_q != 5'd0) && (date_q <= cur_days);
    end

    always_comb begin
        state_d     = state_q;
        date_d      = date_q;
        cur_mon_d   = cur_mon_q;
        cur_year_d  = cur_year_q;
        cur_week_d  = cur_week_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        err_d       = 1'b0;
        done_d      = 1'b0;
        exists_d    = exists_q;
        mon_out_d   = mon_out_q;
        year_out_d  = year_out_q;
        week_out_d  = week_out_q;
        rem_cnt     = cnt_q;

        // busy stays up through the done/err pulse cycle so a coinciding start is dropped.
        if (done_q || err_q) begin
            busy_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (start && !busy_q) begin
                    date_d     = date_in;
                    cur_mon_d  = mon_in;
                    cur_year_d = year_in;
                    cur_week_d = week_in;
                    cnt_d      = steps_in;
                    busy_d     = 1'b1;
                    state_d    = StCheck;
                end
            end
            StCheck: begin
                if (!in_valid) begin
                    state_d = StErr;
                end else if (cnt_q == '0) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!out_valid_q || out_ready) begin
                    if (out_valid_q && (cnt_q == STEPS_W'(1))) begin
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        done_d      = 1'b1;
                        state_d     = StIdle;
                    end else begin
                        rem_cnt     = out_valid_q ? cnt_q - STEPS_W'(1) : cnt_q;
                        cnt_d       = rem_cnt;
                        out_valid_d = 1'b1;
                        out_last_d  = (rem_cnt == STEPS_W'(1));
                        mon_out_d   = nxt_mon;
                        year_out_d  = nxt_year;
                        week_out_d  = nxt_week;
                        exists_d    = nxt_exists;
                        cur_mon_d   = nxt_mon;
                        cur_year_d  = nxt_year;
                        cur_week_d  = nxt_week;
                    end
                end
            end
            StErr: begin
                err_d   = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            date_q      <= '0;
            cur_mon_q   <= '0;
            cur_year_q  <= '0;
            cur_week_q  <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            exists_q    <= 1'b0;
            mon_out_q   <= '0;
            year_out_q  <= '0;
            week_out_q  <= WK_INVALID;
        end else begin
            state_q     <= state_d;
            date_q      <= date_d;
            cur_mon_q   <= cur_mon_d;
            cur_year_q  <= cur_year_d;
            cur_week_q  <= cur_week_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            done_q      <= done_d;
            exists_q    <= exists_d;
            mon_out_q   <= mon_out_d;
            year_out_q  <= year_out_d;
            week_out_q  <= week_out_d;
        end
    end

    assign busy       = busy_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign err        = err_q;
    assign done       = done_q;
    assign exists_out = exists_q;
    assign mon_out    = mon_out_q;
    assign year_out   = year_out_q;
    assign week_out   = week_out_q;

endmodule

// File: tb/tb_week_stepper.sv
// Scoreboard bench for week_stepper; expected beats are queued at stimulus time.
// Expectations follow WEEK_STEPPER_LEAP_EN when it is defined.
module tb_week_stepper;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  date_in = '0;
    logic [3:0]  mon_in = '0;
    logic [11:0] year_in = '0;
    logic [2:0]  week_in = '0;
    logic [3:0]  steps_in = '0;
    logic        busy;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [3:0]  mon_out;
    logic [11:0] year_out;
    logic [2:0]  week_out;
    logic        exists_out;
    logic        out_last;
    logic        err;
    logic        done;

    int          n_checks = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          ready_mode = 0;  // 0: always ready, 1: random, 2: never
    logic [31:0] exp_q[$];

    week_stepper #(.STEPS_W(4), .YEAR_W(12)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .date_in   (date_in),
        .mon_in    (mon_in),
        .year_in   (year_in),
        .week_in   (week_in),
        .steps_in  (steps_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mon_out   (mon_out),
        .year_out  (year_out),
        .week_out  (week_out),
        .exists_out(exists_out),
        .out_last  (out_last),
        .err       (err),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pk(input int mon, input int year, input int week,
                                       input int exists, input int last);
        logic [31:0] v;
        v = {11'd0, 1'(last), 1'(exists), 3'(week), 4'(mon), 12'(year)};
        return v;
    endfunction

    function automatic int model_days(input int m, input int y);
        bit leap;
`ifdef WEEK_STEPPER_LEAP_EN
        leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        leap = 1'b0;
`endif
        if (m == 2) return leap ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    // Returns 1 when the start date is invalid; otherwise queues the expected beats.
    function automatic bit model_push(input int date, input int mon, input int year,
                                      input int week, input int steps);
        int m = mon;
        int y = year;
        int w = week;
        if (mon < 1 || mon > 12 || week == 7 || date == 0 || date > model_days(mon, year))
            return 1'b1;
        for (int i = 0; i < steps; i++) begin
            w = (w + model_days(m, y)) % 7;
            m = m + 1;
            if (m == 13) begin
                m = 1;
                y = (y + 1) % 4096;
            end
            exp_q.push_back(pk(m, y, w, (date <= model_days(m, y)) ? 1 : 0,
                               (i == steps - 1) ? 1 : 0));
        end
        return 1'b0;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        logic [31:0] got;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (out_valid && out_ready) begin
                    got = pk(mon_out, year_out, week_out, exists_out, out_last);
                    if (exp_q.size() == 0) check_eq("beat_unexpected", {31'd0, out_valid}, 32'd0);
                    else check_eq("beat", got, exp_q.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    check_eq("busy_at_done", {31'd0, busy}, 32'd1);
                end
                if (err) err_cnt++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_req(input int date, input int mon, input int year, input int week,
                             input int steps);
        int k = 0;
        while (busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_eq("idle_before_start", {31'd0, busy}, 32'd0);
        date_in  = 5'(date);
        mon_in   = 4'(mon);
        year_in  = 12'(year);
        week_in  = 3'(week);
        steps_in = 4'(steps);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_run(input int date, input int mon, input int year, input int week,
                          input int steps, input bit exp_err);
        int base_done;
        int base_err;
        int k = 0;
        base_done = done_cnt;
        base_err  = err_cnt;
        start_req(date, mon, year, week, steps);
        check_eq("busy_after_start", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1;
        check_eq("valid_n1", {31'd0, out_valid}, 32'd0);
        check_eq("err_n1", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;
        if (exp_err) check_eq("err_n2", {31'd0, err}, 32'd1);
        else if (steps != 0) check_eq("valid_n2", {31'd0, out_valid}, 32'd1);
        while (done_cnt == base_done && err_cnt == base_err && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 300) check_eq("run_timeout", 32'(k), 32'd0);
        @(posedge clk);
        #1;
        check_eq("busy_after_end", {31'd0, busy}, 32'd0);
        check_eq("err_pulses", 32'(err_cnt - base_err), exp_err ? 32'd1 : 32'd0);
        check_eq("done_pulses", 32'(done_cnt - base_done), exp_err ? 32'd0 : 32'd1);
        check_eq("beats_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_reset_vals();
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
        check_eq("rst_last", {31'd0, out_last}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_exists", {31'd0, exists_out}, 32'd0);
        check_eq("rst_week", {29'd0, week_out}, 32'd7);
        check_eq("rst_mon", {28'd0, mon_out}, 32'd0);
        check_eq("rst_year", {20'd0, year_out}, 32'd0);
    endtask

    initial begin
        bit inv;
        int done_before;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic stream
        exp_q.push_back(pk(2, 2023, 3, 1, 0));
        exp_q.push_back(pk(3, 2023, 3, 1, 0));
        exp_q.push_back(pk(4, 2023, 6, 1, 1));
        do_run(15, 1, 2023, 0, 3, 1'b0);

        // Year wrap
        exp_q.push_back(pk(1, 2024, 5, 1, 0));
        exp_q.push_back(pk(2, 2024, 1, 1, 1));
        do_run(5, 12, 2023, 2, 2, 1'b0);

        // Existence
        exp_q.push_back(pk(2, 2023, 5, 0, 0));
        exp_q.push_back(pk(3, 2023, 5, 1, 1));
        do_run(31, 1, 2023, 2, 2, 1'b0);

        // Leap
`ifdef WEEK_STEPPER_LEAP_EN
        exp_q.push_back(pk(3, 2024, 0, 1, 1));
`else
        exp_q.push_back(pk(3, 2024, 6, 1, 1));
`endif
        do_run(10, 2, 2024, 6, 1, 1'b0);

        // Errors
        do_run(15, 13, 2023, 0, 3, 1'b1);
        do_run(0, 5, 2023, 0, 3, 1'b1);
        do_run(15, 5, 2023, 7, 3, 1'b1);
        do_run(31, 4, 2023, 0, 3, 1'b1);
`ifdef WEEK_STEPPER_LEAP_EN
        do_run(29, 2, 1900, 0, 3, 1'b1);
`else
        do_run(29, 2, 2024, 4, 3, 1'b1);
`endif

        // Zero steps finishes with done and no beats
        do_run(15, 1, 2023, 0, 0, 1'b0);

        // Random backpressure against the model
        ready_mode = 1;
        inv = model_push(15, 1, 2023, 0, 3);
        do_run(15, 1, 2023, 0, 3, inv);
        inv = model_push(10, 11, 4095, 3, 4);
        do_run(10, 11, 4095, 3, 4, inv);
        for (int i = 0; i < 6; i++) begin
            int d = $urandom_range(1, 31);
            int m = $urandom_range(1, 12);
            int y = $urandom_range(0, 4095);
            int w = $urandom_range(0, 6);
            int s = $urandom_range(1, 15);
            inv = model_push(d, m, y, w, s);
            do_run(d, m, y, w, s, inv);
        end

        // Reset in the middle of a run
        inv = model_push(20, 3, 2023, 1, 12);
        start_req(20, 3, 2023, 1, 12);
        repeat (8) @(posedge clk);
        #1;
        ready_mode = 2;
        @(posedge clk);
        #1;
        check_eq("valid_before_rst", {31'd0, out_valid}, 32'd1);
        done_before = done_cnt;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_vals();
        rst = 1'b0;
        exp_q.delete();
        ready_mode = 0;
        repeat (4) @(posedge clk);
        #1;
        check_eq("no_done_after_rst", 32'(done_cnt), 32'(done_before));

        exp_q.push_back(pk(2, 2023, 3, 1, 0));
        exp_q.push_back(pk(3, 2023, 3, 1, 0));
        exp_q.push_back(pk(4, 2023, 6, 1, 1));
        do_run(15, 1, 2023, 0, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
